// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised counter family.
// Direction/mode encodings and the bound computation live here.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // MODULUS-1 truncated to the counter width
  function automatic logic [31:0] max_count(
    input int unsigned modulus,
    input int unsigned width
  );
    logic [31:0] m;
    m = 32'(modulus - 1);
    if (width < 32)
      m = m & ((32'd1 << width) - 32'd1);
    return m;
  endfunction

endpackage

// File: rtl/count_bound_detect.sv
// Combinational bound detection for the up/down counter.
// Shared by the next-state logic and the TerminalCount output.
module count_bound_detect
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic             at_max,
  output logic             at_min,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXC =
    WIDTH'(max_count(MODULUS, WIDTH));

  always_comb begin
    at_max = (count == MAXC);
    at_min = (count == '0);
    tc     = (up == DIR_UP) ? at_max : at_min;
  end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, enable, wrap/saturate.
// Wrap is a registered pulse aligned with the wrapped Count value.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic             UpOrDown,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic             TerminalCount,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] MAXC =
    WIDTH'(max_count(MODULUS, WIDTH));
  localparam bit SAT = (SATURATE == MODE_SATURATE);

  logic at_max;
  logic at_min;

  count_bound_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_bound (
    .count  (Count),
    .up     (UpOrDown),
    .at_max (at_max),
    .at_min (at_min),
    .tc     (TerminalCount)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      Count <= '0;
      Wrap  <= 1'b0;
    end else if (Load) begin
      Count <= (LoadValue > MAXC) ? MAXC : LoadValue;
      Wrap  <= 1'b0;
    end else if (Enable) begin
      if (UpOrDown == DIR_UP) begin
        if (!at_max) begin
          Count <= Count + WIDTH'(1);
          Wrap  <= 1'b0;
        end else if (SAT) begin
          Wrap  <= 1'b0;
        end else begin
          Count <= '0;
          Wrap  <= 1'b1;
        end
      end else begin
        if (!at_min) begin
          Count <= Count - WIDTH'(1);
          Wrap  <= 1'b0;
        end else if (SAT) begin
          Wrap  <= 1'b0;
        end else begin
          Count <= MAXC;
          Wrap  <= 1'b1;
        end
      end
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// Scoreboard bench for updown_counter_param in three configurations.
// Stimulus feeds a queue of expected states; a monitor pops and compares.
module tb_updown_counter_param;

  logic       Clk;
  logic       reset;
  logic       Enable;
  logic       UpOrDown;
  logic       Load;
  logic [3:0] LoadValue;

  logic [3:0] cnt [3];
  logic       tc  [3];
  logic       wr  [3];

  int checks = 0;
  int errors = 0;

  int mod [3] = '{10, 10, 16};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};
  int mc  [3];
  bit mw  [3];

  typedef struct packed {
    logic [2:0][4:0] c;
    logic [2:0]      w;
  } exp_t;

  exp_t q[$];

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) d0 (
    .Clk(Clk), .reset(reset), .Enable(Enable), .UpOrDown(UpOrDown),
    .Load(Load), .LoadValue(LoadValue),
    .Count(cnt[0]), .TerminalCount(tc[0]), .Wrap(wr[0])
  );

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) d1 (
    .Clk(Clk), .reset(reset), .Enable(Enable), .UpOrDown(UpOrDown),
    .Load(Load), .LoadValue(LoadValue),
    .Count(cnt[1]), .TerminalCount(tc[1]), .Wrap(wr[1])
  );

  updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) d2 (
    .Clk(Clk), .reset(reset), .Enable(Enable), .UpOrDown(UpOrDown),
    .Load(Load), .LoadValue(LoadValue),
    .Count(cnt[2]), .TerminalCount(tc[2]), .Wrap(wr[2])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(string nm, int i, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %0d expected %0d",
               nm, i, $time, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the count range
  task automatic model_step();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      mw[i] = 1'b0;
      if (reset) begin
        mc[i] = 0;
      end else if (Load) begin
        mc[i] = (int'(LoadValue) > mod[i] - 1) ? mod[i] - 1 : int'(LoadValue);
      end else if (Enable) begin
        if (UpOrDown) begin
          if (sat[i]) begin
            mc[i] = (mc[i] + 1 > mod[i] - 1) ? mod[i] - 1 : mc[i] + 1;
          end else begin
            mw[i] = (mc[i] + 1 >= mod[i]);
            mc[i] = (mc[i] + 1) % mod[i];
          end
        end else begin
          if (sat[i]) begin
            mc[i] = (mc[i] - 1 < 0) ? 0 : mc[i] - 1;
          end else begin
            mw[i] = (mc[i] == 0);
            mc[i] = (mc[i] - 1 + mod[i]) % mod[i];
          end
        end
      end
      e.c[i] = 5'(mc[i]);
      e.w[i] = mw[i];
    end
    q.push_back(e);
  endtask

  task automatic cyc(bit r, bit ld, logic [3:0] lv, bit en, logic ud);
    reset     = r;
    Load      = ld;
    LoadValue = lv;
    Enable    = en;
    UpOrDown  = ud;
    @(posedge Clk);
    model_step();
    #1;
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      for (int i = 0; i < 3; i++) begin
        chk("count", i, int'(cnt[i]), int'(e.c[i]));
        chk("wrap", i, int'(wr[i]), int'(e.w[i]));
        if (!$isunknown(UpOrDown)) begin
          int et;
          et = UpOrDown ? int'(int'(e.c[i]) == mod[i] - 1)
                        : int'(e.c[i] == 0);
          chk("tc", i, int'(tc[i]), et);
        end
      end
    end
  end

  initial begin
    // count up from reset through the bound
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    repeat (12) cyc(0, 0, 0, 1, 1);
    // count down from reset
    cyc(1, 0, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 1, 0);
    // long runs to exercise saturation
    cyc(1, 0, 0, 0, 1);
    repeat (15) cyc(0, 0, 0, 1, 1);
    repeat (15) cyc(0, 0, 0, 1, 0);
    // load priority, clamp, hold with unknown inputs
    cyc(0, 1, 4'd7, 1, 1);
    cyc(0, 1, 4'd12, 1, 0);
    repeat (5) cyc(0, 0, 4'bxxxx, 0, 1'bx);
    // reset overrides a simultaneous load
    cyc(0, 1, 4'd5, 0, 1);
    cyc(1, 1, 4'd3, 1, 1);
    repeat (3) cyc(0, 0, 0, 1, 1);
    // full-range wrap then immediate direction flip
    cyc(1, 0, 0, 0, 1);
    repeat (20) cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 4'd15, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 7) == 0,
          4'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 0, 1);
    repeat (4) @(negedge Clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
